// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time and buffers the reply for decode.
// Response to o_inst_valid is one registered cycle; decode backpressure holds the buffer and blocks the next fetch.
module fetch_ctrl #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic             clk,
   input  logic             s_reset,
   input  logic             i_redirect_valid,
   input  logic [WIDTH-1:0] i_redirect_addr,
   output logic             o_imem_req,
   output logic [WIDTH-1:0] o_imem_addr,
   input  logic             i_imem_ready,
   input  logic             i_imem_rvalid,
   input  logic [WIDTH-1:0] i_imem_rdata,
   output logic             o_inst_valid,
   output logic [WIDTH-1:0] o_inst,
   output logic [WIDTH-1:0] o_inst_pc,
   input  logic             i_decode_ready,
   output logic [31:0]      o_fetch_count
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_REQ,
      ST_WAIT,
      ST_OUT
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             kill_q, kill_d;
   logic [WIDTH-1:0] inst_q, inst_d;
   logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
   logic             inst_vld_q, inst_vld_d;
   logic [31:0]      cnt_q, cnt_d;

   logic [WIDTH-1:0] redir_tgt;
   logic             redir_act;
   logic             rsp_load;
   logic             consume;

   // Redirects are word-aligned and have no effect while booting.
   assign redir_tgt = i_redirect_addr & ~WIDTH'(3);
   assign redir_act = i_redirect_valid && (state_q != ST_BOOT);
   assign rsp_load  = (state_q == ST_WAIT) && i_imem_rvalid && !kill_q && !i_redirect_valid;
   assign consume   = (state_q == ST_OUT) && i_decode_ready && !i_redirect_valid;

   always_ff @(posedge clk) begin
      if (s_reset) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = ST_REQ;
         ST_REQ: begin
            if (i_imem_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_imem_rvalid) begin
               state_d = (i_redirect_valid || kill_q) ? ST_REQ : ST_OUT;
            end
         end
         ST_OUT: begin
            if (i_redirect_valid || i_decode_ready) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      o_imem_req = (state_q == ST_REQ);
   end

   always_comb begin
      pc_d       = pc_q;
      kill_d     = kill_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      inst_vld_d = inst_vld_q;
      cnt_d      = cnt_q;

      if (redir_act) begin
         pc_d = redir_tgt;
      end else if (rsp_load) begin
         pc_d = pc_q + WIDTH'(4);
      end

      // A request already accepted when the redirect lands returns a stale word that must be dropped.
      if (state_q == ST_REQ && redir_act && i_imem_ready) begin
         kill_d = 1'b1;
      end else if (state_q == ST_WAIT) begin
         if (i_imem_rvalid) begin
            kill_d = 1'b0;
         end else if (i_redirect_valid) begin
            kill_d = 1'b1;
         end
      end

      if (rsp_load) begin
         inst_d     = i_imem_rdata;
         inst_pc_d  = pc_q;
         inst_vld_d = 1'b1;
      end

      if (state_q == ST_OUT && (i_redirect_valid || i_decode_ready)) begin
         inst_vld_d = 1'b0;
      end

      if (consume) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (s_reset) begin
         pc_q       <= RESET_ADDR;
         kill_q     <= 1'b0;
         inst_q     <= '0;
         inst_pc_q  <= '0;
         inst_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         kill_q     <= kill_d;
         inst_q     <= inst_d;
         inst_pc_q  <= inst_pc_d;
         inst_vld_q <= inst_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_imem_addr   = pc_q;
   assign o_inst_valid  = inst_vld_q;
   assign o_inst        = inst_q;
   assign o_inst_pc     = inst_pc_q;
   assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed cycle vectors, hand-written corner sequences, then random traffic
// scored against a transaction-level model of which PCs decode must receive.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        s_reset;
   logic        rv;
   logic [31:0] ra;
   logic        rdy;
   logic        rvl;
   logic [31:0] rd;
   logic        dr;
   logic        req;
   logic [31:0] addr;
   logic        ivld;
   logic [31:0] inst;
   logic [31:0] ipc;
   logic [31:0] cnt;

   int checks = 0;
   int errors = 0;

   fetch_ctrl #(.WIDTH(32), .RESET_ADDR(32'h0000_0000)) dut (
      .clk              (clk),
      .s_reset          (s_reset),
      .i_redirect_valid (rv),
      .i_redirect_addr  (ra),
      .o_imem_req       (req),
      .o_imem_addr      (addr),
      .i_imem_ready     (rdy),
      .i_imem_rvalid    (rvl),
      .i_imem_rdata     (rd),
      .o_inst_valid     (ivld),
      .o_inst           (inst),
      .o_inst_pc        (ipc),
      .i_decode_ready   (dr),
      .o_fetch_count    (cnt)
   );

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] ra;
      logic        rdy;
      logic        rvl;
      logic [31:0] rd;
      logic        dr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_inst;
      logic [31:0] e_ipc;
      logic [31:0] e_cnt;
      logic        chk_buf;
   } vec_t;

   vec_t vecs[$];

   // Model state for the random phase.
   logic [31:0] exp_pc;
   logic [31:0] exp_cnt;
   logic [31:0] pend_addr;
   bit          pend;
   int          lat;
   int          deliveries;
   logic        n_rv, n_rdy, n_rvl, n_dr;
   logic [31:0] n_ra, n_rd;

   function automatic logic [31:0] fdat(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic y,
                        input logic l, input logic [31:0] d, input logic k);
      s_reset = r;
      rv      = v;
      ra      = a;
      rdy     = y;
      rvl     = l;
      rd      = d;
      dr      = k;
   endtask

   task automatic add(input logic r, input logic v, input logic [31:0] a, input logic y,
                      input logic l, input logic [31:0] d, input logic k,
                      input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                      input logic [31:0] e_inst, input logic [31:0] e_ipc,
                      input logic [31:0] e_cnt, input logic cb);
      vec_t t;
      t = '{r, v, a, y, l, d, k, e_req, e_addr, e_vld, e_inst, e_ipc, e_cnt, cb};
      vecs.push_back(t);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);

      //  rst rv ra        rdy rvl rd                 dr | req addr      vld inst              ipc       cnt chk
      add(1, 0, 0,         0, 0, 0,                  0,  0, 32'h0,     0, 32'h0,            32'h0,     0, 1);
      add(1, 0, 0,         0, 0, 0,                  0,  0, 32'h0,     0, 32'h0,            32'h0,     0, 1);
      add(0, 0, 0,         0, 0, 0,                  0,  0, 32'h0,     0, 32'h0,            32'h0,     0, 1);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'h0,     0, 0,                0,         0, 0);
      add(0, 0, 0,         0, 1, fdat(32'h0),        0,  0, 32'h0,     0, 0,                0,         0, 0);
      add(0, 0, 0,         0, 0, 0,                  1,  0, 32'h4,     1, fdat(32'h0),      32'h0,     0, 1);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'h4,     0, 0,                0,         1, 0);
      add(0, 0, 0,         0, 1, fdat(32'h4),        0,  0, 32'h4,     0, 0,                0,         1, 0);
      add(0, 0, 0,         0, 0, 0,                  1,  0, 32'h8,     1, fdat(32'h4),      32'h4,     1, 1);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'h8,     0, 0,                0,         2, 0);
      add(0, 0, 0,         0, 1, fdat(32'h8),        0,  0, 32'h8,     0, 0,                0,         2, 0);
      add(0, 0, 0,         0, 0, 0,                  1,  0, 32'hC,     1, fdat(32'h8),      32'h8,     2, 1);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'hC,     0, 0,                0,         3, 0);
      add(0, 0, 0,         0, 1, fdat(32'hC),        0,  0, 32'hC,     0, 0,                0,         3, 0);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0,      1, 1, 32'hBAD0_0000,      0,  0, 32'h10,    1, fdat(32'hC),      32'hC,     3, 1);
      add(0, 0, 0,         0, 0, 0,                  1,  0, 32'h10,    1, fdat(32'hC),      32'hC,     3, 1);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'h10,    0, 0,                0,         4, 0);
      add(0, 1, 32'h100,   0, 0, 0,                  0,  0, 32'h10,    0, 0,                0,         4, 0);
      add(0, 0, 0,         0, 1, fdat(32'h10),       0,  0, 32'h100,   0, 0,                0,         4, 0);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'h100,   0, 0,                0,         4, 0);
      add(0, 0, 0,         0, 1, fdat(32'h100),      0,  0, 32'h100,   0, 0,                0,         4, 0);
      add(0, 0, 0,         0, 0, 0,                  1,  0, 32'h104,   1, fdat(32'h100),    32'h100,   4, 1);
      add(0, 1, 32'h203,   1, 0, 0,                  0,  1, 32'h104,   0, 0,                0,         5, 0);
      add(0, 0, 0,         0, 1, fdat(32'h104),      0,  0, 32'h200,   0, 0,                0,         5, 0);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'h200,   0, 0,                0,         5, 0);
      add(0, 0, 0,         0, 1, fdat(32'h200),      0,  0, 32'h200,   0, 0,                0,         5, 0);
      add(0, 1, 32'h300,   0, 0, 0,                  1,  0, 32'h204,   1, fdat(32'h200),    32'h200,   5, 1);
      add(0, 1, 32'h407,   0, 0, 0,                  0,  1, 32'h300,   0, 0,                0,         5, 0);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'h404,   0, 0,                0,         5, 0);
      add(0, 1, 32'h500,   0, 1, fdat(32'h404),      0,  0, 32'h404,   0, 0,                0,         5, 0);
      add(0, 0, 0,         1, 0, 0,                  0,  1, 32'h500,   0, 0,                0,         5, 0);
      add(0, 0, 0,         0, 1, fdat(32'h500),      0,  0, 32'h500,   0, 0,                0,         5, 0);
      add(0, 0, 0,         0, 0, 0,                  1,  0, 32'h504,   1, fdat(32'h500),    32'h500,   5, 1);
      add(0, 0, 0,         0, 0, 0,                  0,  1, 32'h504,   0, 0,                0,         6, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         chk($sformatf("v%0d_req", i), req, vecs[i].e_req);
         chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
         chk($sformatf("v%0d_vld", i), ivld, vecs[i].e_vld);
         chk($sformatf("v%0d_cnt", i), cnt, vecs[i].e_cnt);
         if (vecs[i].chk_buf) begin
            chk($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
            chk($sformatf("v%0d_ipc", i), ipc, vecs[i].e_ipc);
         end
         drive(vecs[i].rst, vecs[i].rv, vecs[i].ra, vecs[i].rdy, vecs[i].rvl, vecs[i].rd, vecs[i].dr);
      end

      // Reset while waiting, stale rvalid and a redirect arriving during BOOT.
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      chk("mid_wait_req", req, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("boot_req", req, 0);
      chk("boot_vld", ivld, 0);
      chk("boot_cnt", cnt, 0);
      chk("boot_addr", addr, 32'h0);
      drive(0, 1, 32'h800, 0, 1, 32'hDEAD_BEEF, 0);
      @(negedge clk);
      chk("post_boot_req", req, 1);
      chk("post_boot_addr", addr, 32'h0);
      chk("post_boot_vld", ivld, 0);
      drive(0, 0, 0, 0, 0, 0, 0);

      // Address wrap at the top of the space.
      @(negedge clk);
      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      @(negedge clk);
      chk("wrap_req", req, 1);
      chk("wrap_addr", addr, 32'hFFFF_FFFC);
      drive(0, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 1, fdat(32'hFFFF_FFFC), 0);
      @(negedge clk);
      chk("wrap_vld", ivld, 1);
      chk("wrap_ipc", ipc, 32'hFFFF_FFFC);
      chk("wrap_inst", inst, fdat(32'hFFFF_FFFC));
      chk("wrap_next_addr", addr, 32'h0);
      drive(0, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("wrap_req_zero", req, 1);
      chk("wrap_addr_zero", addr, 32'h0);
      chk("wrap_cnt", cnt, 1);

      // Random phase.
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      exp_pc     = 32'h0;
      exp_cnt    = 32'h0;
      pend       = 0;
      lat        = 0;
      deliveries = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c != 0) @(negedge clk);
         n_rv  = (c != 0) && ($urandom_range(0, 15) == 0);
         n_ra  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
         n_rdy = $urandom_range(0, 1) == 1;
         n_dr  = $urandom_range(0, 3) != 0;
         n_rd  = $urandom;
         n_rvl = 1'b0;
         if (pend && lat == 0) begin
            n_rvl = 1'b1;
            n_rd  = fdat(pend_addr);
         end else if (!pend && $urandom_range(0, 7) == 0) begin
            n_rvl = 1'b1;
         end
         drive(0, n_rv, n_ra, n_rdy, n_rvl, n_rd, n_dr);

         if (ivld && n_dr && !n_rv) begin
            chk("rnd_pc", ipc, exp_pc);
            chk("rnd_inst", inst, fdat(exp_pc));
            chk("rnd_cnt", cnt, exp_cnt);
            exp_pc  = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
            deliveries++;
         end
         if (n_rv) exp_pc = n_ra & ~32'h3;
         if (req) chk("rnd_one_outstanding", 32'(pend), 0);
         if (pend) begin
            if (n_rvl) pend = 0;
            else lat--;
         end else if (req && n_rdy) begin
            pend      = 1;
            pend_addr = addr;
            lat       = $urandom_range(0, 3);
         end
      end
      @(negedge clk);
      chk("rnd_final_cnt", cnt, exp_cnt);
      chk("rnd_progress", 32'(deliveries >= 100), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
